pipelined_controller: RTL and testbench
=======================================

Name: pipelined_controller

Overview:
- Control unit for the five-stage ARM-subset pipeline. Decodes the Decode-stage instruction and drives the Decode-stage mux selects.
- Carries the remaining control bits through Execute/Memory/Writeback pipeline registers that run in lockstep with the datapath's data registers.
- Evaluates condition codes in Execute against an internal NZCV flags register. Cancels every side effect of a failed-condition instruction.

Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded into the flags register on reset.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- InstrDec  in  32  Decode-stage instruction; uses [31:12]
- ALUFlagsExe  in  4  ALU flags {N,Z,C,V} from the Execute stage
- RegSrcDec  out  2  register-address mux selects, combinational
- ImmSrcDec  out  2  extend-unit format select, combinational
- ALUSrcExe  out  1  0 selects rd2, 1 selects ExtImm
- ALUControlExe  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- MemWriteMem  out  1  data-memory write enable, condition-gated
- MemtoRegWri  out  1  Writeback result mux select
- RegWriteWri  out  1  register-file write enable, condition-gated
- PCSrcWri  out  1  load PC from ResultWri, condition-gated
- FlagsOut  out  4  current NZCV register, for debug display

Behaviour:
- Decode (combinational on InstrDec): op=[27:26], funct=[25:20], rd=[15:12].
  - op=00, data-processing. ImmSrc=00, RegSrc=00, ALUSrc=funct[5]. cmd=funct[4:1].
    - AND 0000: ALUCtl 10, RegWrite 1.
    - SUB 0010: ALUCtl 01, RegWrite 1.
    - ADD 0100: ALUCtl 00, RegWrite 1.
    - ORR 1100: ALUCtl 11, RegWrite 1.
    - CMP 1010: ALUCtl 01, RegWrite 0, S forced to 1.
    - Any other cmd is a NOP: no writes of any kind.
    - FlagWrite[1] (NZ) = S. FlagWrite[0] (CV) = S & arithmetic command (ADD/SUB/CMP).
  - op=01, memory. ALUSrc=1, ImmSrc=01. ALUCtl = 00 if U (funct[3]) = 1, else 01.
    - LDR (funct[0]=1): RegWrite 1, MemtoReg 1, RegSrc 00.
    - STR (funct[0]=0): MemWrite 1, RegSrc 10.
  - op=10, branch. Branch 1, ALUSrc 1, ImmSrc 10, RegSrc 01, ALUCtl 00.
  - op=11: NOP, all controls 0.
  - PCS = Branch | (RegWrite & rd==4'hF).
- D→E register: {cond, FlagWrite, PCS, RegWrite, MemWrite, MemtoReg, ALUSrc, ALUCtl}.
- Condition check in Execute (combinational, uses the current flags register, not ALUFlagsExe):
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z.
  - GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1; 1111 → 0.
- CondEx gates PCS, RegWrite, MemWrite and FlagWrite before they enter the E→M register.
- Flags register: on the clock edge, NZ←ALUFlagsExe[3:2] if FlagWrite[1]&CondEx; CV←ALUFlagsExe[1:0] if FlagWrite[0]&CondEx. An instruction in Decode sees flags only once the setter has left Execute.
- Latency from instruction in Decode:
  - ALUSrcExe/ALUControlExe: +1 cycle.
  - MemWriteMem: +2.
  - MemtoRegWri/RegWriteWri/PCSrcWri: +3.
- Reset: all pipeline control bits 0, flags = RESET_FLAGS, all registered outputs 0. Reset asserted mid-instruction discards all in-flight controls with no partial writes. The Decode outputs stay combinational and follow InstrDec throughout.
- Unknown op or cmd never asserts RegWrite, MemWrite or PCSrc.

Optional Feature:
- Macro CTRL_FLUSH_EN.
- Defined: adds input FlushExe (1 bit). When FlushExe=1 at a clock edge, the D→E register loads all-zero controls (bubble). cond is loaded as 1110 and FlagWrite as 0, so the bubble is an inert AL no-op. FlushExe has priority over a new decode.
- Undefined: no port; the D→E register loads every cycle.

Test Plan:
- Reset: assert reset mid-stream with RESET_FLAGS=0 → all registered outputs 0 and FlagsOut=0000 immediately, asynchronously.
- ADDS then BEQ: ADDS R1,R0,R0 (0xE0901000) with ALUFlagsExe=0100 in its Execute cycle → FlagsOut=0100 next cycle. A following BEQ (0x0A000002) reaches Execute with CondEx=1 → PCSrcWri=1 three cycles after its Decode.
- BNE with Z=1: BNE (0x1A000002) with FlagsOut Z=1 → PCSrcWri, RegWriteWri and MemWriteMem stay 0 through Writeback.
- STR/LDR: STR R2,[R3,#4] (0xE5832004) → RegSrcDec=10, ImmSrcDec=01, ALUSrcExe=1, ALUControlExe=00, MemWriteMem=1 at +2. LDR (0xE5932004) → MemtoRegWri=1 and RegWriteWri=1 at +3.
- Flag-setting and PC writes:
  - CMP R1,R2 (0xE1510002) → RegWriteWri=0, ALUControlExe=01, all four flags updated.
  - ANDS → CV unchanged.
  - ADD PC,… (rd=15) → PCSrcWri=1.
- CTRL_FLUSH_EN: FlushExe=1 while ADD is in Decode → ALUControlExe=00, ALUSrcExe=0, and no writes at +2/+3. With the macro off, the same stream executes normally.

Source files
------------

// File: rtl/pipelined_controller_if.sv
// Control-side signal bundle between the pipeline datapath and pipelined_controller.
// FlushExe exists only when CTRL_FLUSH_EN is defined.
interface pipelined_controller_if;
    logic [31:0] InstrDec;
    logic [3:0]  ALUFlagsExe;
`ifdef CTRL_FLUSH_EN
    logic        FlushExe;
`endif
    logic [1:0]  RegSrcDec;
    logic [1:0]  ImmSrcDec;
    logic        ALUSrcExe;
    logic [1:0]  ALUControlExe;
    logic        MemWriteMem;
    logic        MemtoRegWri;
    logic        RegWriteWri;
    logic        PCSrcWri;
    logic [3:0]  FlagsOut;

    // Datapath side: supplies the instruction and ALU flags, consumes the controls.
    modport master (
        output InstrDec, ALUFlagsExe,
`ifdef CTRL_FLUSH_EN
        output FlushExe,
`endif
        input  RegSrcDec, ImmSrcDec, ALUSrcExe, ALUControlExe,
        input  MemWriteMem, MemtoRegWri, RegWriteWri, PCSrcWri, FlagsOut
    );

    modport slave (
        input  InstrDec, ALUFlagsExe,
`ifdef CTRL_FLUSH_EN
        input  FlushExe,
`endif
        output RegSrcDec, ImmSrcDec, ALUSrcExe, ALUControlExe,
        output MemWriteMem, MemtoRegWri, RegWriteWri, PCSrcWri, FlagsOut
    );
endinterface

// File: rtl/pipelined_controller.sv
// Control unit for the five-stage ARM-subset pipeline: decode, condition check, NZCV flags.
// Optional macro CTRL_FLUSH_EN adds FlushExe, which loads an inert bubble into Execute.
module pipelined_controller #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input logic             clk,
    input logic             reset,
    pipelined_controller_if.slave bus
);

    typedef struct packed {
        logic [3:0] cond;
        logic [1:0] flagwrite;
        logic       pcs;
        logic       regwrite;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic [1:0] aluctl;
    } de_t;

    typedef struct packed {
        logic pcs;
        logic regwrite;
        logic memwrite;
        logic memtoreg;
    } em_t;

    typedef struct packed {
        logic pcs;
        logic regwrite;
        logic memtoreg;
    } mw_t;

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;
    logic       branch;
    logic       s_bit;
    logic       arith;
    de_t        dec;
    de_t        de_q;
    em_t        em_q;
    mw_t        mw_q;
    logic [3:0] flags_q;
    logic       condex;

    assign op    = bus.InstrDec[27:26];
    assign funct = bus.InstrDec[25:20];
    assign rd    = bus.InstrDec[15:12];
    assign cmd   = funct[4:1];

    always_comb begin
        dec           = '0;
        dec.cond      = bus.InstrDec[31:28];
        bus.RegSrcDec = 2'b00;
        bus.ImmSrcDec = 2'b00;
        branch        = 1'b0;
        s_bit         = 1'b0;
        arith         = 1'b0;
        case (op)
            2'b00: begin
                dec.alusrc = funct[5];
                s_bit      = funct[0];
                case (cmd)
                    4'b0000: begin dec.aluctl = 2'b10; dec.regwrite = 1'b1; end
                    4'b0010: begin dec.aluctl = 2'b01; dec.regwrite = 1'b1; arith = 1'b1; end
                    4'b0100: begin dec.aluctl = 2'b00; dec.regwrite = 1'b1; arith = 1'b1; end
                    4'b1100: begin dec.aluctl = 2'b11; dec.regwrite = 1'b1; end
                    4'b1010: begin dec.aluctl = 2'b01; s_bit = 1'b1; arith = 1'b1; end
                    // Unsupported commands are NOPs, including their S bit.
                    default: s_bit = 1'b0;
                endcase
            end
            2'b01: begin
                dec.alusrc    = 1'b1;
                bus.ImmSrcDec = 2'b01;
                dec.aluctl    = funct[3] ? 2'b00 : 2'b01;
                if (funct[0]) begin
                    dec.regwrite = 1'b1;
                    dec.memtoreg = 1'b1;
                end else begin
                    dec.memwrite  = 1'b1;
                    bus.RegSrcDec = 2'b10;
                end
            end
            2'b10: begin
                branch        = 1'b1;
                dec.alusrc    = 1'b1;
                bus.ImmSrcDec = 2'b10;
                bus.RegSrcDec = 2'b01;
            end
            default: ;
        endcase
        dec.flagwrite = {s_bit, s_bit & arith};
        dec.pcs       = branch | (dec.regwrite & (rd == 4'hF));
    end

    // Flags are read from the register, so a setter still in Execute is not visible here.
    always_comb begin
        condex = 1'b0;
        case (de_q.cond)
            4'b0000: condex = flags_q[2];
            4'b0001: condex = ~flags_q[2];
            4'b0010: condex = flags_q[1];
            4'b0011: condex = ~flags_q[1];
            4'b0100: condex = flags_q[3];
            4'b0101: condex = ~flags_q[3];
            4'b0110: condex = flags_q[0];
            4'b0111: condex = ~flags_q[0];
            4'b1000: condex = flags_q[1] & ~flags_q[2];
            4'b1001: condex = ~flags_q[1] | flags_q[2];
            4'b1010: condex = (flags_q[3] == flags_q[0]);
            4'b1011: condex = (flags_q[3] != flags_q[0]);
            4'b1100: condex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: condex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_q <= '0;
`ifdef CTRL_FLUSH_EN
        end else if (bus.FlushExe) begin
            de_q      <= '0;
            de_q.cond <= 4'b1110;
`endif
        end else begin
            de_q <= dec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            em_q    <= '0;
            mw_q    <= '0;
            flags_q <= RESET_FLAGS;
        end else begin
            em_q.pcs      <= de_q.pcs & condex;
            em_q.regwrite <= de_q.regwrite & condex;
            em_q.memwrite <= de_q.memwrite & condex;
            em_q.memtoreg <= de_q.memtoreg;
            mw_q.pcs      <= em_q.pcs;
            mw_q.regwrite <= em_q.regwrite;
            mw_q.memtoreg <= em_q.memtoreg;
            if (de_q.flagwrite[1] & condex) flags_q[3:2] <= bus.ALUFlagsExe[3:2];
            if (de_q.flagwrite[0] & condex) flags_q[1:0] <= bus.ALUFlagsExe[1:0];
        end
    end

    assign bus.ALUSrcExe     = de_q.alusrc;
    assign bus.ALUControlExe = de_q.aluctl;
    assign bus.MemWriteMem   = em_q.memwrite;
    assign bus.MemtoRegWri   = mw_q.memtoreg;
    assign bus.RegWriteWri   = mw_q.regwrite;
    assign bus.PCSrcWri      = mw_q.pcs;
    assign bus.FlagsOut      = flags_q;

endmodule

// File: tb/tb_pipelined_controller.sv
// Directed bench for pipelined_controller: hand-computed control values at each pipeline stage.
module tb_pipelined_controller;

  localparam logic [31:0] NOP    = 32'hEC000000;
  localparam logic [31:0] ADDS   = 32'hE0901000;
  localparam logic [31:0] BEQ    = 32'h0A000002;
  localparam logic [31:0] BNE    = 32'h1A000002;
  localparam logic [31:0] STR    = 32'hE5832004;
  localparam logic [31:0] LDR    = 32'hE5932004;
  localparam logic [31:0] CMP    = 32'hE1510002;
  localparam logic [31:0] ANDS   = 32'hE0110002;
  localparam logic [31:0] ADDSNE = 32'h10901000;
  localparam logic [31:0] EORS   = 32'hE0310002;
  localparam logic [31:0] ADDPC  = 32'hE080F001;
  localparam logic [31:0] ADDI   = 32'hE2801005;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  pipelined_controller_if bus ();

  pipelined_controller #(.RESET_FLAGS(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [31:0] instr);
    bus.InstrDec = instr;
    step(1);
    bus.InstrDec = NOP;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b1;
    bus.InstrDec    = NOP;
    bus.ALUFlagsExe = 4'b0000;
`ifdef CTRL_FLUSH_EN
    bus.FlushExe = 1'b0;
`endif
    #1;
    check("rst_alusrc", 32'(bus.ALUSrcExe), 0);
    check("rst_aluctl", 32'(bus.ALUControlExe), 0);
    check("rst_memwrite", 32'(bus.MemWriteMem), 0);
    check("rst_regwrite", 32'(bus.RegWriteWri), 0);
    check("rst_pcsrc", 32'(bus.PCSrcWri), 0);
    check("rst_flags", 32'(bus.FlagsOut), 0);
    @(negedge clk);
    reset = 1'b0;
    step(2);

    // ADDS sets Z, following BEQ is taken
    bus.InstrDec = ADDS;
    #1;
    check("adds_regsrc", 32'(bus.RegSrcDec), 0);
    check("adds_immsrc", 32'(bus.ImmSrcDec), 0);
    step(1);
    check("adds_alusrc", 32'(bus.ALUSrcExe), 0);
    check("adds_aluctl", 32'(bus.ALUControlExe), 0);
    bus.ALUFlagsExe = 4'b0100;
    bus.InstrDec = BEQ;
    #1;
    check("beq_regsrc", 32'(bus.RegSrcDec), 1);
    check("beq_immsrc", 32'(bus.ImmSrcDec), 2);
    step(1);
    bus.ALUFlagsExe = 4'b0000;
    bus.InstrDec = NOP;
    check("adds_flags", 32'(bus.FlagsOut), 4'b0100);
    check("beq_alusrc", 32'(bus.ALUSrcExe), 1);
    step(1);
    check("adds_regwrite", 32'(bus.RegWriteWri), 1);
    check("adds_pcsrc", 32'(bus.PCSrcWri), 0);
    step(1);
    check("beq_pcsrc", 32'(bus.PCSrcWri), 1);
    check("beq_regwrite", 32'(bus.RegWriteWri), 0);

    // BNE with Z=1 is cancelled
    issue(BNE);
    step(1);
    check("bne_memwrite", 32'(bus.MemWriteMem), 0);
    step(1);
    check("bne_pcsrc", 32'(bus.PCSrcWri), 0);
    check("bne_regwrite", 32'(bus.RegWriteWri), 0);

    // STR then LDR back to back
    bus.InstrDec = STR;
    #1;
    check("str_regsrc", 32'(bus.RegSrcDec), 2);
    check("str_immsrc", 32'(bus.ImmSrcDec), 1);
    step(1);
    bus.InstrDec = LDR;
    check("str_alusrc", 32'(bus.ALUSrcExe), 1);
    check("str_aluctl", 32'(bus.ALUControlExe), 0);
    step(1);
    bus.InstrDec = NOP;
    check("str_memwrite", 32'(bus.MemWriteMem), 1);
    step(1);
    check("ldr_memwrite", 32'(bus.MemWriteMem), 0);
    check("str_regwrite", 32'(bus.RegWriteWri), 0);
    step(1);
    check("ldr_memtoreg", 32'(bus.MemtoRegWri), 1);
    check("ldr_regwrite", 32'(bus.RegWriteWri), 1);

    // CMP updates all four flags, writes no register
    issue(CMP);
    check("cmp_aluctl", 32'(bus.ALUControlExe), 1);
    bus.ALUFlagsExe = 4'b1011;
    step(1);
    bus.ALUFlagsExe = 4'b0000;
    check("cmp_flags", 32'(bus.FlagsOut), 4'b1011);
    step(1);
    check("cmp_regwrite", 32'(bus.RegWriteWri), 0);

    // ANDS updates NZ only
    issue(ANDS);
    check("ands_aluctl", 32'(bus.ALUControlExe), 2);
    bus.ALUFlagsExe = 4'b0100;
    step(1);
    bus.ALUFlagsExe = 4'b0000;
    check("ands_flags", 32'(bus.FlagsOut), 4'b0111);
    step(1);
    check("ands_regwrite", 32'(bus.RegWriteWri), 1);

    // ADDSNE with Z=1: no flag or register write
    issue(ADDSNE);
    bus.ALUFlagsExe = 4'b1000;
    step(1);
    bus.ALUFlagsExe = 4'b0000;
    check("addsne_flags", 32'(bus.FlagsOut), 4'b0111);
    step(1);
    check("addsne_regwrite", 32'(bus.RegWriteWri), 0);

    // Unsupported command (EORS) is a full NOP
    issue(EORS);
    bus.ALUFlagsExe = 4'b1000;
    step(1);
    bus.ALUFlagsExe = 4'b0000;
    check("eors_flags", 32'(bus.FlagsOut), 4'b0111);
    check("eors_memwrite", 32'(bus.MemWriteMem), 0);
    step(1);
    check("eors_regwrite", 32'(bus.RegWriteWri), 0);
    check("eors_pcsrc", 32'(bus.PCSrcWri), 0);

    // ADD to PC
    issue(ADDPC);
    step(2);
    check("addpc_pcsrc", 32'(bus.PCSrcWri), 1);
    check("addpc_regwrite", 32'(bus.RegWriteWri), 1);

    // Asynchronous reset with STR in Memory and LDR in Execute
    issue(STR);
    bus.InstrDec = LDR;
    step(1);
    bus.InstrDec = STR;
    check("pre_rst_memwrite", 32'(bus.MemWriteMem), 1);
    check("pre_rst_alusrc", 32'(bus.ALUSrcExe), 1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_memwrite", 32'(bus.MemWriteMem), 0);
    check("midrst_alusrc", 32'(bus.ALUSrcExe), 0);
    check("midrst_flags", 32'(bus.FlagsOut), 0);
    check("midrst_regsrc", 32'(bus.RegSrcDec), 2);
    bus.InstrDec = NOP;
    @(negedge clk);
    reset = 1'b0;
    step(1);
    check("postrst_regwrite1", 32'(bus.RegWriteWri), 0);
    step(1);
    check("postrst_regwrite2", 32'(bus.RegWriteWri), 0);
    check("postrst_memtoreg", 32'(bus.MemtoRegWri), 0);

    // Flush of an ADD immediate in Decode
    bus.InstrDec = ADDI;
`ifdef CTRL_FLUSH_EN
    bus.FlushExe = 1'b1;
`endif
    step(1);
`ifdef CTRL_FLUSH_EN
    bus.FlushExe = 1'b0;
`endif
    bus.InstrDec = NOP;
    check("flush_aluctl", 32'(bus.ALUControlExe), 0);
`ifdef CTRL_FLUSH_EN
    check("flush_alusrc", 32'(bus.ALUSrcExe), 0);
`else
    check("flush_alusrc", 32'(bus.ALUSrcExe), 1);
`endif
    step(1);
    check("flush_memwrite", 32'(bus.MemWriteMem), 0);
    step(1);
`ifdef CTRL_FLUSH_EN
    check("flush_regwrite", 32'(bus.RegWriteWri), 0);
`else
    check("flush_regwrite", 32'(bus.RegWriteWri), 1);
`endif
    check("flush_pcsrc", 32'(bus.PCSrcWri), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
